// File: rtl/pong_physics_engine_pkg.sv
// Shared types and helpers for the pong game-logic core.
// State/winner encodings, vertical speed bounds, paddle hit-angle mapping.
package pong_physics_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam logic [1:0] WIN_NONE  = 2'd0;
    localparam logic [1:0] WIN_LEFT  = 2'd1;
    localparam logic [1:0] WIN_RIGHT = 2'd2;

    localparam int DY_MIN = -3;
    localparam int DY_MAX = 3;

    // Map the ball's offset along the paddle face to one of seven bands,
    // centre band gives a flat return, outer bands the steepest angle.
    function automatic logic signed [3:0] hit_dy(input logic [9:0] off,
                                                 input int pad_h);
        logic [15:0] band;
        logic signed [3:0] b;
        band = (16'(off) * 16'd7) / 16'(pad_h);
        if (band > 16'(DY_MAX - DY_MIN))
            band = 16'(DY_MAX - DY_MIN);
        b = 4'(band);
        return b + 4'(DY_MIN);
    endfunction

endpackage

// File: rtl/pong_physics_engine_paddle.sv
// Paddle position register: steps once per enabled frame and
// clamps to the playfield between the top and bottom walls.
module pong_paddle_ctrl #(
    parameter int V_RES    = 480,
    parameter int BORDER   = 5,
    parameter int PAD_H    = 40,
    parameter int PAD_STEP = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic [9:0] y
);

    localparam logic signed [11:0] Y_LO = 12'(BORDER + 1);
    localparam logic signed [11:0] Y_HI = 12'(V_RES - BORDER - 1 - PAD_H);
    localparam logic signed [11:0] STEP = 12'(PAD_STEP);
    localparam logic [9:0]         Y_RST = 10'((V_RES - PAD_H) / 2);

    logic signed [11:0] y_raw;
    logic signed [11:0] y_clip;

    // Step toward the pressed direction; conflicting or no input holds.
    always_comb begin
        y_raw = $signed({2'b00, y});
        if (up && !dn)
            y_raw = $signed({2'b00, y}) - STEP;
        else if (dn && !up)
            y_raw = $signed({2'b00, y}) + STEP;
        y_clip = y_raw;
        if (y_raw < Y_LO)
            y_clip = Y_LO;
        else if (y_raw > Y_HI)
            y_clip = Y_HI;
    end

    // Position register, updated only on an enabled frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y <= Y_RST;
        else if (en)
            y <= y_clip[9:0];
    end

endmodule

// File: rtl/pong_physics_engine.sv
// Pong game-logic core: serve/play/over sequencing, ball physics,
// paddle hits, wall bounces, misses and scoring, once per frame.
module pong_physics_engine
    import pong_physics_engine_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BORDER       = 5,
    parameter int PAD_W        = 15,
    parameter int PAD_H        = 40,
    parameter int PAD_STEP     = 5,
    parameter int P1_X         = 40,
    parameter int P2_X         = 585,
    parameter int BALL_R       = 15,
    parameter int SPEED_INIT   = 3,
    parameter int SPEED_MAX    = 8,
    parameter int HITS_PER_UP  = 4,
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                           CLOCK_50,
    input  logic                           RESET_N,
    input  logic                           frame_tick,
    input  logic                           run,
    input  logic                           p1_up,
    input  logic                           p1_dn,
    input  logic                           p2_up,
    input  logic                           p2_dn,
    output logic [9:0]                     pad1_y,
    output logic [9:0]                     pad2_y,
    output logic [9:0]                     ball_x,
    output logic [9:0]                     ball_y,
    output logic [$clog2(WIN_SCORE+1)-1:0] score1,
    output logic [$clog2(WIN_SCORE+1)-1:0] score2,
    output logic [1:0]                     state,
    output logic [1:0]                     winner,
    output logic                           show_score
);

    localparam int SW  = $clog2(WIN_SCORE + 1);
    localparam int SPW = $clog2(SPEED_MAX + 1);
    localparam int HCW = $clog2(HITS_PER_UP + 1);
    localparam int SCW = $clog2(SERVE_FRAMES + 1);

    localparam logic signed [11:0] X_MAX  = 12'(H_RES - 1);
    localparam logic signed [11:0] HIT_L  = 12'(P1_X + PAD_W + BALL_R);
    localparam logic signed [11:0] HIT_R  = 12'(P2_X - BALL_R);
    localparam logic signed [11:0] MISS_L = 12'(BORDER + BALL_R);
    localparam logic signed [11:0] MISS_R = 12'(H_RES - BORDER - BALL_R);
    localparam logic signed [11:0] WALL_T = 12'(BORDER + BALL_R);
    localparam logic signed [11:0] WALL_B = 12'(V_RES - BORDER - BALL_R);

    localparam logic [9:0] X_MID   = 10'(H_RES / 2);
    localparam logic [9:0] Y_MID   = 10'(V_RES / 2);
    localparam logic [9:0] X_RET_L = 10'(P1_X + PAD_W + BALL_R + 1);
    localparam logic [9:0] X_RET_R = 10'(P2_X - BALL_R - 1);
    localparam logic [9:0] Y_TOP   = 10'(BORDER + BALL_R + 1);
    localparam logic [9:0] Y_BOT   = 10'(V_RES - BORDER - BALL_R - 1);

    game_state_t st, st_next;

    logic                 tick_en;
    logic                 pad_en;
    logic                 dir;
    logic signed [3:0]    dy;
    logic [SPW-1:0]       speed;
    logic [HCW-1:0]       hits;
    logic [SCW-1:0]       serve_cnt;

    logic signed [11:0]   spd_s;
    logic signed [11:0]   sx_raw;
    logic signed [11:0]   sx;
    logic signed [11:0]   sy;
    logic                 in_l, in_r;
    logic                 hit_l, hit_r, hit;
    logic                 miss_l, miss_r, miss;
    logic                 wall_t, wall_b;
    logic                 game_won, serve_done;
    logic [9:0]           pad_hit;
    logic [9:0]           off;
    logic signed [3:0]    dy_hit, dy_eff;

    assign tick_en = frame_tick & run;
    assign pad_en  = tick_en & (st != ST_OVER);

    pong_paddle_ctrl #(
        .V_RES(V_RES), .BORDER(BORDER), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)
    ) u_pad1 (
        .clk(CLOCK_50), .rst_n(RESET_N), .en(pad_en),
        .up(p1_up), .dn(p1_dn), .y(pad1_y)
    );

    pong_paddle_ctrl #(
        .V_RES(V_RES), .BORDER(BORDER), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)
    ) u_pad2 (
        .clk(CLOCK_50), .rst_n(RESET_N), .en(pad_en),
        .up(p2_up), .dn(p2_dn), .y(pad2_y)
    );

    // Ball candidate move, hit/miss detection and wall response.
    always_comb begin
        spd_s  = $signed(12'(speed));
        sx_raw = dir ? $signed({2'b00, ball_x}) + spd_s
                     : $signed({2'b00, ball_x}) - spd_s;
        sx = sx_raw;
        if (sx_raw < 12'sd0)
            sx = 12'sd0;
        else if (sx_raw > X_MAX)
            sx = X_MAX;

        in_l = ({1'b0, ball_y} >= {1'b0, pad1_y}) &&
               ({1'b0, ball_y} <= {1'b0, pad1_y} + 11'(PAD_H));
        in_r = ({1'b0, ball_y} >= {1'b0, pad2_y}) &&
               ({1'b0, ball_y} <= {1'b0, pad2_y} + 11'(PAD_H));
        hit_l = !dir && (sx <= HIT_L) && in_l;
        hit_r = dir && (sx >= HIT_R) && in_r;
        hit   = hit_l | hit_r;

        miss_l = !hit && (sx <= MISS_L);
        miss_r = !hit && (sx >= MISS_R);
        miss   = miss_l | miss_r;

        pad_hit = hit_l ? pad1_y : pad2_y;
        off     = ball_y - pad_hit;
        dy_hit  = hit_dy(off, PAD_H);
        dy_eff  = hit ? dy_hit : dy;

        sy     = $signed({2'b00, ball_y}) + 12'(dy_eff);
        wall_t = (dy_eff < 4'sd0) && (sy <= WALL_T);
        wall_b = (dy_eff > 4'sd0) && (sy >= WALL_B);

        game_won = (miss_r && score1 == SW'(WIN_SCORE - 1)) ||
                   (miss_l && score2 == SW'(WIN_SCORE - 1));
        serve_done = (serve_cnt == SCW'(SERVE_FRAMES - 1));
    end

    // Game state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            st <= ST_IDLE;
        else
            st <= st_next;
    end

    // Sequencing: start, serve hold, point outcome, game over release.
    always_comb begin
        st_next = st;
        unique case (st)
            ST_IDLE:  if (tick_en) st_next = ST_SERVE;
            ST_SERVE: if (tick_en && serve_done) st_next = ST_PLAY;
            ST_PLAY:  if (tick_en && miss)
                          st_next = game_won ? ST_OVER : ST_SERVE;
            ST_OVER:  if (!run) st_next = ST_IDLE;
            default:  st_next = st;
        endcase
    end

    // State-derived outputs for the renderer.
    always_comb begin
        state      = st;
        show_score = (st != ST_PLAY);
    end

    // Ball, speed, serve timer, scores and winner.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ball_x    <= X_MID;
            ball_y    <= Y_MID;
            dir       <= 1'b1;
            dy        <= 4'sd0;
            speed     <= SPW'(SPEED_INIT);
            hits      <= '0;
            serve_cnt <= '0;
            score1    <= '0;
            score2    <= '0;
            winner    <= WIN_NONE;
        end else if (st == ST_OVER && !run) begin
            score1 <= '0;
            score2 <= '0;
            winner <= WIN_NONE;
        end else if (tick_en) begin
            unique case (st)
                ST_SERVE: begin
                    serve_cnt <= serve_done ? '0 : serve_cnt + SCW'(1);
                end
                ST_PLAY: begin
                    if (miss) begin
                        ball_x    <= X_MID;
                        ball_y    <= Y_MID;
                        dy        <= 4'sd0;
                        dir       <= miss_r;
                        speed     <= SPW'(SPEED_INIT);
                        hits      <= '0;
                        serve_cnt <= '0;
                        if (miss_r && score1 < SW'(WIN_SCORE))
                            score1 <= score1 + SW'(1);
                        if (miss_l && score2 < SW'(WIN_SCORE))
                            score2 <= score2 + SW'(1);
                        if (game_won)
                            winner <= miss_r ? WIN_LEFT : WIN_RIGHT;
                    end else begin
                        if (hit_l)
                            ball_x <= X_RET_L;
                        else if (hit_r)
                            ball_x <= X_RET_R;
                        else
                            ball_x <= sx[9:0];
                        if (hit) begin
                            dir <= hit_l;
                            if (hits == HCW'(HITS_PER_UP - 1)) begin
                                hits <= '0;
                                if (speed < SPW'(SPEED_MAX))
                                    speed <= speed + SPW'(1);
                            end else begin
                                hits <= hits + HCW'(1);
                            end
                        end
                        if (wall_t || wall_b) begin
                            dy     <= -dy_eff;
                            ball_y <= wall_t ? Y_TOP : Y_BOT;
                        end else begin
                            dy     <= dy_eff;
                            ball_y <= sy[9:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
